// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address, keeps a 2-entry
// FIFO of fetched words, and supports jump redirect and halt on HALT_OP.
module fetch_unit #(
    parameter int          ADDR_W  = 4,
    parameter int          DATA_W  = 16,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic [3:0]        o_opcode,
    output logic [2:0]        o_rx,
    output logic [2:0]        o_ry,
    output logic [2:0]        o_rz,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic              o_halted
);

    // state   | meaning
    // IDLE    | not fetching; buffer and pending response retained
    // FETCH   | issuing one address per edge while buffer space allows
    // HALTED  | HALT word captured; no issue until a jump
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic                r_pending;
    logic [1:0]          r_count;
    logic [DATA_W-1:0]   r_buf_data0, r_buf_data1;
    logic [ADDR_W-1:0]   r_buf_pc0, r_buf_pc1;

    logic                w_pop;
    logic                w_push;
    logic                w_halt_det;
    logic                w_can_fetch;
    logic                w_issue;
    logic [2:0]          w_occ;

    assign w_pop      = o_instr_valid & i_instr_ready;
    assign w_push     = r_pending & ~i_jump;
    assign w_halt_det = w_push & (i_mem_q[DATA_W-1 -: 4] == HALT_OP);
    // Slots already committed after this edge: held entries plus the one in flight.
    assign w_occ      = {1'b0, r_count} + {2'b0, r_pending} - {2'b0, w_pop};

    always_comb begin
        w_state_nx  = r_state;
        w_can_fetch = 1'b0;
        if (i_jump) begin
            w_state_nx = i_run ? S_FETCH : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        w_state_nx  = S_FETCH;
                        w_can_fetch = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!i_run) w_state_nx = S_IDLE;
                    else        w_can_fetch = 1'b1;
                end
                default: w_state_nx = S_HALTED;
            endcase
            if (w_halt_det) w_state_nx = S_HALTED;
        end
        w_issue = w_can_fetch & ~w_halt_det & (w_occ < 3'd2);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_pend_pc <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_issue;
            if (w_issue) r_pend_pc <= r_pc;
            if (i_jump)       r_pc <= i_jump_target;
            else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // FIFO with entry 0 as head; jump flushes but leaves stale data invisible.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count     <= 2'd0;
            r_buf_data0 <= '0;
            r_buf_data1 <= '0;
            r_buf_pc0   <= '0;
            r_buf_pc1   <= '0;
        end else if (i_jump) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf_data0 <= i_mem_q;
                        r_buf_pc0   <= r_pend_pc;
                    end else begin
                        r_buf_data1 <= i_mem_q;
                        r_buf_pc1   <= r_pend_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf_data0 <= r_buf_data1;
                    r_buf_pc0   <= r_buf_pc1;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf_data0 <= i_mem_q;
                        r_buf_pc0   <= r_pend_pc;
                    end else begin
                        r_buf_data0 <= r_buf_data1;
                        r_buf_pc0   <= r_buf_pc1;
                        r_buf_data1 <= i_mem_q;
                        r_buf_pc1   <= r_pend_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_address = r_pc;
    assign o_mem_wren    = 1'b0;
    assign o_instr       = r_buf_data0;
    assign o_instr_pc    = r_buf_pc0;
    assign o_opcode      = r_buf_data0[15:12];
    assign o_rx          = r_buf_data0[11:9];
    assign o_ry          = r_buf_data0[8:6];
    assign o_rz          = r_buf_data0[5:3];
    assign o_instr_valid = (r_count != 2'd0);
    assign o_halted      = (r_state == S_HALTED);

endmodule
